dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single-port data memory between two requesters: port 0 = CPU load/store unit, port 1 = DMA/loader engine.
- Sits between the requesters and the data memory. Drives memRead/memWrite/address/writeData and samples readData.
- Round-robin arbitration with an optional bounded lock for bursts. Read data is returned one cycle after grant.

Parameters:
- ADDR_W, 32, requester/memory address width (byte address)
- DATA_W, 32, data width
- MAX_LOCK, 8, max consecutive grants one requester may hold via lock before forced release (>=1)

Ports:
- clk  in  1  clock; memory writes commit on posedge
- rst_n  in  1  asynchronous active-low reset
- req  in  2  per-requester request, held until gnt
- we  in  2  per-requester write enable (1=store, 0=load)
- lock  in  2  per-requester keep-ownership hint for bursts
- addr0, addr1  in  ADDR_W  request addresses
- wdata0, wdata1  in  DATA_W  store data
- gnt  out  2  one-hot acceptance, combinational, same cycle as the issued access
- rvalid  out  2  one-hot, one cycle after a granted load (or a rejected access)
- rdata  out  DATA_W  registered read data, valid with rvalid
- err  out  1  access rejected, qualifies rvalid
- memRead, memWrite  out  1  memory strobes
- address  out  ADDR_W  memory address
- writeData  out  DATA_W  memory write data
- readData  in  DATA_W  combinational memory read data

Behaviour:
- Reset: gnt=0, rvalid=0, rdata=0, err=0, memRead=memWrite=0, address=0, writeData=0. prio pointer=0 (port 0 preferred). FSM=IDLE, lock counter=0.
- FSM states:
  - IDLE: no owner; winner = requesting port. If both request, winner = prio. Gnt to winner; prio <= ~winner after every grant.
  - LOCKED: entered when the winner is granted with lock=1. Owner keeps priority regardless of prio. The other port gets gnt only in cycles where the owner has req=0.
  - LOCKED -> IDLE: owner lock=0, OR the lock counter reaches MAX_LOCK granted cycles (forced release, prio <= other port).
- Grant cycle t:
  - memRead=~we[w], memWrite=we[w], address/writeData mux from the winner, all combinational.
  - The store commits at posedge ending t.
  - A load samples readData into rdata at that posedge; rvalid[w]=1 in t+1 for exactly one cycle.
  - Stores produce no rvalid.
- Throughput: one access per cycle; back-to-back grants allowed. rdata holds its last value when rvalid=0.
- No request: memRead=memWrite=0, address/writeData=0, gnt=0.
- Requester must hold req/we/addr/wdata stable until gnt. The arbiter does not re-check dropped requests.
- Simultaneous: both req with lock=0 alternate 0,1,0,1... Same-address store by one port and load by the other are serialized by grant order; the later load sees the new data.
- Reset mid-operation: all state cleared asynchronously, pending rvalid dropped, no memory strobe.

Optional Feature:
- Macro: DMEM_RANGE_CHECK_EN.
- Defined:
  - Any access with addr[ADDR_W-1:12] != 0 (outside 4 KiB) is granted but issues no memRead/memWrite.
  - Next cycle: rvalid[w]=1, err=1, rdata=0. This applies to both loads and stores.
- Undefined: upper address bits are passed through unchecked and err is tied 0.

Decomposition:
- Shared package dmem_pkg: ADDR_W/DATA_W defaults, DMEM_BYTES=4096, requester index constants REQ_CPU=0, REQ_DMA=1, FSM state encoding (IDLE, LOCKED).
- One natural sub-module: rr_arb2 (2-way round-robin pick with lock override, combinational pick + registered prio/lock counter). The top holds the datapath mux and response registers.

Test Plan:
- Reset, then req[0]=1 we=1 addr0=0x10 wdata0=0xDEADBEEF; next cycle req[0] load 0x10 -> gnt[0] each cycle, memWrite then memRead, rvalid[0]=1 with rdata=0xDEADBEEF one cycle after the load grant.
- Both req held, lock=0, loads for 6 cycles -> gnt sequence 01,10,01,10,01,10 (port0 first); rvalid follows one cycle behind.
- Port1 lock=1 with 12 loads, port0 requesting throughout, MAX_LOCK=8 -> port1 granted 8 consecutive cycles, then port0 granted, then alternation.
- Port0 stores 0x5A5A5A5A to 0x40 while port1 loads 0x40 in the same cycle (prio=0) -> port0 granted first, port1 granted next cycle, rdata=0x5A5A5A5A.
- rst_n pulsed low in the cycle after a load grant -> rvalid=0, gnt=0, no memory strobe; after release, prio=port0.
- With DMEM_RANGE_CHECK_EN, load addr0=0x1000 -> memRead=0, next cycle rvalid[0]=1, err=1, rdata=0. Without the macro -> memRead=1, err=0.

Source files
------------

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared widths, requester indices and arbiter FSM encoding for dmem_arbiter
package dmem_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  localparam int DMEM_BYTES = 4096;
  localparam int RANGE_LSB  = $clog2(DMEM_BYTES);

  localparam int REQ_CPU = 0;
  localparam int REQ_DMA = 1;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin pick with a bounded lock override for bursts
module rr_arb2
  import dmem_pkg::*;
#(
  parameter int MAX_LOCK = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic [1:0] lock,
  output logic [1:0] gnt
);

  localparam int CW = $clog2(MAX_LOCK + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_LOCK);

  arb_state_t    state, state_n;
  logic          prio, prio_n;
  logic          owner, owner_n;
  logic [CW-1:0] cnt, cnt_n, cnt_inc;
  logic          win;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      prio  <= 1'(REQ_CPU);
      owner <= 1'(REQ_CPU);
      cnt   <= '0;
    end else begin
      state <= state_n;
      prio  <= prio_n;
      owner <= owner_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    gnt     = 2'b00;
    state_n = state;
    prio_n  = prio;
    owner_n = owner;
    cnt_n   = cnt;
    cnt_inc = cnt + 1'b1;

    // A locked owner pre-empts; an idle owner lets the other port through.
    if (state == LOCKED && req[owner])
      gnt = onehot2(owner);
    else if (req == 2'b11)
      gnt = onehot2(prio);
    else
      gnt = req;

    if (!rst_n)
      gnt = 2'b00;

    win = gnt[1];
    if (|gnt)
      prio_n = ~win;

    case (state)
      IDLE: begin
        if (|gnt && lock[win]) begin
          owner_n = win;
          if (MAX_LOCK > 1) begin
            state_n = LOCKED;
            cnt_n   = CW'(1);
          end
        end
      end
      LOCKED: begin
        if (gnt[owner])
          cnt_n = cnt_inc;
        if (!lock[owner] || (gnt[owner] && cnt_inc >= CNT_MAX)) begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - shares single-port data memory between CPU and DMA requesters
// Optional DMEM_RANGE_CHECK_EN rejects accesses outside the 4 KiB window with err.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int MAX_LOCK = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req,
  input  logic [1:0]        we,
  input  logic [1:0]        lock,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic [1:0]        gnt,
  output logic [1:0]        rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic              memRead,
  output logic              memWrite,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] writeData,
  input  logic [DATA_W-1:0] readData
);

  logic              win;
  logic              any;
  logic              is_load;
  logic              bad;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  rr_arb2 #(.MAX_LOCK(MAX_LOCK)) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .lock  (lock),
    .gnt   (gnt)
  );

  assign any       = |gnt;
  assign win       = gnt[REQ_DMA];
  assign sel_addr  = win ? addr1 : addr0;
  assign sel_wdata = win ? wdata1 : wdata0;

`ifdef DMEM_RANGE_CHECK_EN
  assign bad = any && (sel_addr[ADDR_W-1:RANGE_LSB] != '0);
`else
  assign bad = 1'b0;
`endif

  assign is_load   = any && !we[win];
  assign memRead   = is_load && !bad;
  assign memWrite  = any && we[win] && !bad;
  assign address   = any ? sel_addr : '0;
  assign writeData = any ? sel_wdata : '0;

  // Rejected accesses answer like a load so the requester always gets closure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid <= 2'b00;
      rdata  <= '0;
      err    <= 1'b0;
    end else begin
      rvalid <= (is_load || bad) ? onehot2(win) : 2'b00;
      err    <= bad;
      if (bad)
        rdata <= '0;
      else if (is_load)
        rdata <= readData;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - randomized self-checking bench for dmem_arbiter against a transaction-level model
module tb_dmem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int ML = 8;
`ifdef DMEM_RANGE_CHECK_EN
  localparam bit RANGE_EN = 1'b1;
`else
  localparam bit RANGE_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    req, we, lock;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic [1:0]    gnt, rvalid;
  logic [DW-1:0] rdata;
  logic          err, memRead, memWrite;
  logic [AW-1:0] address;
  logic [DW-1:0] writeData, readData;

  logic [DW-1:0] mem     [256];
  logic [DW-1:0] ref_mem [256];

  int checks = 0;
  int errors = 0;

  // reference model state
  int         prio, owner, held;
  logic [1:0] e_rv, cur_eg;
  logic       e_err;
  logic [DW-1:0] e_rd;
  logic [1:0] gnt_log[$];

  logic [1:0]    eg;
  int            w;
  logic          bad, ld;
  logic [AW-1:0] wa;
  logic [DW-1:0] wd;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_LOCK(ML)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .we        (we),
    .lock      (lock),
    .addr0     (addr0),
    .addr1     (addr1),
    .wdata0    (wdata0),
    .wdata1    (wdata1),
    .gnt       (gnt),
    .rvalid    (rvalid),
    .rdata     (rdata),
    .err       (err),
    .memRead   (memRead),
    .memWrite  (memWrite),
    .address   (address),
    .writeData (writeData),
    .readData  (readData)
  );

  assign readData = mem[address[9:2]];

  always @(posedge clk) begin
    if (memWrite) mem[address[9:2]] = writeData;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_gnt", gnt, 0);
      chk("rst_rvalid", rvalid, 0);
      chk("rst_err", err, 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_memread", memRead, 0);
      chk("rst_memwrite", memWrite, 0);
      chk("rst_address", address, 0);
      chk("rst_wdata", writeData, 0);
      prio = 0; owner = -1; held = 0;
      e_rv = 0; e_err = 0; e_rd = 0; cur_eg = 0;
    end else begin
      if (owner >= 0 && req[owner])   eg = (owner == 1) ? 2'b10 : 2'b01;
      else if (req == 2'b11)          eg = (prio == 1) ? 2'b10 : 2'b01;
      else                            eg = req;
      w   = eg[1] ? 1 : 0;
      wa  = (w == 1) ? addr1 : addr0;
      wd  = (w == 1) ? wdata1 : wdata0;
      bad = RANGE_EN && (eg != 0) && ((wa >> 12) != 0);
      ld  = (eg != 0) && !we[w];

      chk("gnt", gnt, eg);
      chk("memread", memRead, ld && !bad);
      chk("memwrite", memWrite, (eg != 0) && we[w] && !bad);
      chk("address", address, (eg != 0) ? wa : 0);
      chk("writedata", writeData, (eg != 0) ? wd : 0);
      chk("rvalid", rvalid, e_rv);
      chk("err", err, e_err);
      chk("rdata", rdata, e_rd);
      gnt_log.push_back(gnt);
      cur_eg = eg;

      e_rv = 0; e_err = 0;
      if (eg != 0) begin
        if (bad) begin
          e_rv = eg; e_err = 1; e_rd = 0;
        end else if (we[w]) begin
          ref_mem[wa[9:2]] = wd;
        end else begin
          e_rv = eg; e_rd = ref_mem[wa[9:2]];
        end
        prio = 1 - w;
        if (owner < 0 && lock[w]) begin
          owner = w; held = 1;
        end else if (owner == w) begin
          held++;
        end
      end
      if (owner >= 0 && (!lock[owner] || held >= ML)) begin
        owner = -1; held = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [AW-1:0] a;
    for (int i = 0; i < 256; i++) begin
      mem[i]     = (i * 32'h01010101) ^ 32'hA500_0000;
      ref_mem[i] = mem[i];
    end
    rst_n = 1'b0; req = 0; we = 0; lock = 0;
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // both loading, no lock: strict alternation starting at port 0
    gnt_log.delete();
    req = 2'b11; we = 2'b00; addr0 = 32'h20; addr1 = 32'h24;
    repeat (6) step();
    req = 2'b00;
    for (int i = 0; i < 6; i++) chk("alt_gnt", gnt_log[i], (i % 2) ? 2'b10 : 2'b01);

    // same-address store (port 0) and load (port 1) in one cycle
    gnt_log.delete();
    we = 2'b01; addr0 = 32'h40; wdata0 = 32'h5A5A5A5A; addr1 = 32'h40; req = 2'b11;
    step();
    req = 2'b10;
    step();
    req = 2'b00;
    @(negedge clk);
    chk("raw_gnt0", gnt_log[0], 2'b01);
    chk("raw_gnt1", gnt_log[1], 2'b10);
    chk("raw_rvalid", rvalid, 2'b10);
    chk("raw_rdata", rdata, 32'h5A5A5A5A);
    step();

    // port 0 store then load of the same address
    req = 2'b01; we = 2'b01; addr0 = 32'h10; wdata0 = 32'hDEADBEEF;
    step();
    we = 2'b00;
    step();
    req = 2'b00;
    @(negedge clk);
    chk("sl_rvalid", rvalid, 2'b01);
    chk("sl_rdata", rdata, 32'hDEADBEEF);
    step();

    // port 1 locked burst against a continuously requesting port 0 (prio at port 1)
    gnt_log.delete();
    we = 2'b00; addr0 = 32'h80; addr1 = 32'h84; lock = 2'b10; req = 2'b11;
    repeat (10) step();
    req = 2'b00; lock = 2'b00;
    for (int i = 0; i < 8; i++) chk("lock_gnt", gnt_log[i], 2'b10);
    chk("lock_release", gnt_log[8], 2'b01);
    chk("lock_after", gnt_log[9], 2'b10);

    // reset in the cycle after a load grant
    req = 2'b01; we = 2'b00; addr0 = 32'h10;
    step();
    rst_n = 1'b0; req = 2'b11;
    @(negedge clk);
    chk("rstmid_rvalid", rvalid, 2'b00);
    chk("rstmid_gnt", gnt, 2'b00);
    chk("rstmid_strobe", {memRead, memWrite}, 2'b00);
    step();
    rst_n = 1'b1;
    gnt_log.delete();
    step();
    req = 2'b00;
    chk("rstmid_prio", gnt_log[0], 2'b01);

    // access above the 4 KiB window
    req = 2'b01; we = 2'b00; addr0 = 32'h1000;
    @(negedge clk);
    chk("rng_memread", memRead, RANGE_EN ? 1'b0 : 1'b1);
    step();
    req = 2'b00;
    @(negedge clk);
    chk("rng_rvalid", rvalid, 2'b01);
    chk("rng_err", err, RANGE_EN);
    chk("rng_rdata", rdata, RANGE_EN ? 32'h0 : ref_mem[0]);
    step();

    // randomized traffic with held requests, bursts and occasional resets
    for (int c = 0; c < 3000; c++) begin
      for (int p = 0; p < 2; p++) begin
        if (!req[p] || cur_eg[p]) begin
          lock[p] = ($urandom_range(0, 9) < 3);
          if ($urandom_range(0, 9) < 7) begin
            req[p] = 1'b1;
            we[p]  = 1'($urandom_range(0, 1));
            a = AW'($urandom_range(0, 255)) << 2;
            if ($urandom_range(0, 9) == 0) a = a | 32'h1000;
            if (p == 1) begin addr1 = a; wdata1 = $urandom; end
            else        begin addr0 = a; wdata0 = $urandom; end
          end else begin
            req[p] = 1'b0;
          end
        end
      end
      if ($urandom_range(0, 599) == 0) begin
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
      end
      step();
    end

    req = 2'b00;
    repeat (2) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
